// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE with round-robin arbitration on contention.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    owner_t     owner;
    owner_t     last_owner;
    logic       drop;
    logic       is_store;
    logic [3:0] cnt;

    logic dm_pend;
    logic if_pend;
    logic grant_dm;
    logic grant_if;
    logic flush_hit;

    // On a tie the requester that did not own the previous access wins.
    assign dm_pend   = dm_read | dm_write;
    assign if_pend   = if_req & ~if_flush;
    assign grant_dm  = dm_pend & (~if_pend | (last_owner == OWN_IF));
    assign grant_if  = if_pend & ~grant_dm;
    assign flush_hit = if_flush & (owner == OWN_IF);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_IF;
            drop       <= 1'b0;
            is_store   <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_ready   <= 1'b0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_we     <= dm_write;
                        is_store   <= dm_write;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        owner      <= OWN_DM;
                        last_owner <= OWN_DM;
                        drop       <= 1'b0;
                    end else if (grant_if) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        is_store   <= 1'b0;
                        mem_addr   <= if_addr;
                        owner      <= OWN_IF;
                        last_owner <= OWN_IF;
                        drop       <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= CNT_INIT;
                    state  <= WAIT;
                    if (flush_hit) begin
                        drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (flush_hit) begin
                        drop <= 1'b1;
                    end
                    // A flush arriving in the capture cycle still cancels the fetch result.
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        if (owner == OWN_DM) begin
                            dm_ready <= 1'b1;
                            if (!is_store) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else if (!(drop | if_flush)) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    drop     <= 1'b0;
                    owner    <= OWN_NONE;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a timeline model predicts every access from grant time,
// plus directed scenarios with literal expectations and a MEM_LAT=1 instance.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_req = 1'b0;
    logic        if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        if_ready, dm_ready, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        if_req1 = 1'b0;
    logic [31:0] mem_rdata1 = 32'h0000_0013;
    logic        if_ready1, dm_ready1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .if_req(if_req1), .if_addr(32'h44), .if_flush(1'b0),
        .if_ready(if_ready1), .if_rdata(if_rdata1),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ready(dm_ready1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] memarr [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Memory: captures each strobe, returns data exactly LAT cycles later, garbage otherwise.
    bit          mem_pending = 1'b0;
    int          iss_c = 0;
    logic [31:0] iss_a = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            mem_pending = 1'b0;
        end else if (mem_en) begin
            mem_pending = 1'b1;
            iss_c = cyc;
            iss_a = mem_addr;
            if (mem_we) memarr[mem_addr[9:2]] = mem_wdata;
        end
    end

    always @(posedge clk) begin
        #1;
        if (mem_pending && cyc == iss_c + LAT) mem_rdata = memarr[iss_a[9:2]];
        else mem_rdata = $urandom;
    end

    // Timeline model: an access granted in cycle g strobes at g+1, readies at g+LAT+2,
    // and the arbiter accepts the next request at g+LAT+3.
    bit          m_act = 1'b0;
    int          m_g = 0;
    bit          m_dm = 1'b0;
    bit          m_write = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_last_dm = 1'b0;
    logic [31:0] m_rd = '0;
    logic [31:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;

    always @(negedge clk) begin : model
        bit at_done, in_acc, en_now, dm_p, if_p, win_dm;
        if (!rstn) begin
            m_act = 1'b0; m_last_dm = 1'b0; m_drop = 1'b0;
            e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
            check_output("rst_busy", busy, 0);
            check_output("rst_mem_en", mem_en, 0);
            check_output("rst_if_ready", if_ready, 0);
            check_output("rst_dm_ready", dm_ready, 0);
        end else begin
            in_acc  = m_act && cyc >= m_g + 1 && cyc <= m_g + LAT + 2;
            at_done = m_act && cyc == m_g + LAT + 2;
            en_now  = m_act && cyc == m_g + 1;
            if (m_act && !m_dm && cyc >= m_g + 1 && cyc <= m_g + LAT + 1 && if_flush) m_drop = 1'b1;
            if (at_done) begin
                if (!m_dm && !m_drop) e_if_rdata = m_rd;
                if (m_dm && !m_write) e_dm_rdata = m_rd;
            end
            check_output("busy", busy, in_acc);
            check_output("mem_en", mem_en, en_now);
            check_output("mem_we", mem_we, en_now && m_write);
            check_output("mem_addr", mem_addr, e_mem_addr);
            if (en_now && m_write) check_output("mem_wdata", mem_wdata, e_mem_wdata);
            check_output("if_ready", if_ready, at_done && !m_dm && !m_drop);
            check_output("dm_ready", dm_ready, at_done && m_dm);
            check_output("if_rdata", if_rdata, e_if_rdata);
            check_output("dm_rdata", dm_rdata, e_dm_rdata);
            if (at_done) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                dm_p   = dm_read | dm_write;
                if_p   = if_req & ~if_flush;
                win_dm = dm_p && (!if_p || !m_last_dm);
                if (dm_p || if_p) begin
                    m_act = 1'b1; m_g = cyc; m_dm = win_dm; m_last_dm = win_dm; m_drop = 1'b0;
                    m_write = win_dm && dm_write;
                    e_mem_addr = win_dm ? dm_addr : if_addr;
                    if (win_dm) e_mem_wdata = dm_wdata;
                    m_rd = memarr[e_mem_addr[9:2]];
                end
            end
        end
    end

    task automatic new_dm();
        int k;
        k = $urandom_range(3, 0);
        dm_read  = (k != 2);
        dm_write = (k >= 2);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
    endtask

    // Legal requester behaviour: hold until ready, occasionally redirect the fetch.
    task automatic apply_stimulus();
        if (if_flush) begin
            if_flush = 1'b0;
            if_req = 1'b1;
            if_addr = $urandom;
        end else if (if_req) begin
            if (if_ready) begin
                if_req = ($urandom_range(1, 0) == 1);
                if_addr = $urandom;
            end else if ($urandom_range(15, 0) == 0) begin
                if_flush = 1'b1;
            end
        end else if ($urandom_range(2, 0) == 0) begin
            if_req = 1'b1;
            if_addr = $urandom;
        end else if ($urandom_range(31, 0) == 0) begin
            if_flush = 1'b1;
        end
        if (dm_read | dm_write) begin
            if (dm_ready) begin
                dm_read = 1'b0;
                dm_write = 1'b0;
                if ($urandom_range(1, 0) == 1) new_dm();
            end
        end else if ($urandom_range(2, 0) == 0) begin
            new_dm();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memarr[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        memarr[8'h40] = 32'h0000_0013;
        memarr[8'h10] = 32'hCAFE_0040;
        memarr[8'h00] = 32'h0000_0093;
        memarr[8'h20] = 32'h0000_0513;

        do_reset();
        step(); if_req = 1'b1; if_addr = 32'h100;
        step(); check_output("t1_mem_en", mem_en, 1); check_output("t1_mem_addr", mem_addr, 32'h100);
        step(); step(); check_output("t1_early_ready", if_ready, 0);
        step(); check_output("t1_if_ready", if_ready, 1); check_output("t1_if_rdata", if_rdata, 32'h13);
        if_req = 1'b0;

        do_reset();
        step(); if_req = 1'b1; if_addr = 32'h0; dm_read = 1'b1; dm_addr = 32'h40;
        step(); check_output("t2_mem_en", mem_en, 1); check_output("t2_dm_first", mem_addr, 32'h40);
        repeat (3) step();
        check_output("t2_dm_ready", dm_ready, 1); check_output("t2_dm_rdata", dm_rdata, 32'hCAFE_0040);
        dm_read = 1'b0;
        step(); check_output("t2_idle_gap", busy, 0);
        step(); check_output("t2_if_en", mem_en, 1); check_output("t2_if_addr", mem_addr, 32'h0);
        repeat (3) step();
        check_output("t2_if_ready", if_ready, 1); check_output("t2_if_rdata", if_rdata, 32'h93);
        if_req = 1'b0;

        step(); dm_write = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        step(); check_output("t3_mem_we", mem_we, 1); check_output("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        repeat (3) step();
        check_output("t3_dm_ready", dm_ready, 1); check_output("t3_dm_rdata_kept", dm_rdata, 32'hCAFE_0040);
        dm_write = 1'b0;

        step(); if_req = 1'b1; if_addr = 32'h300;
        repeat (2) step(); if_flush = 1'b1;
        step(); if_flush = 1'b0; if_req = 1'b0;
        step(); check_output("t4_ready_dropped", if_ready, 0);
        step(); check_output("t4_idle", busy, 0); check_output("t4_rdata_kept", if_rdata, 32'h93);
        if_req = 1'b1; if_addr = 32'h80;
        step(); check_output("t4_mem_en", mem_en, 1); check_output("t4_mem_addr", mem_addr, 32'h80);
        repeat (3) step();
        check_output("t4_if_ready", if_ready, 1); check_output("t4_if_rdata", if_rdata, 32'h513);
        if_req = 1'b0;

        step(); if_req = 1'b1; if_addr = 32'h100; if_req1 = 1'b1;
        repeat (2) step(); check_output("t6_busy_wait", busy, 1);
        #1 rstn = 1'b0;
        #1;
        check_output("t6_rst_busy", busy, 0); check_output("t6_rst_en", mem_en, 0);
        check_output("t6_rst_ready", if_ready, 0); check_output("t6_rst_busy1", busy1, 0);
        check_output("t6_rst_en1", mem_en1, 0); check_output("t6_rst_ready1", if_ready1, 0);
        if_req = 1'b0; if_req1 = 1'b0;
        step(); rstn = 1'b1;
        step(); if_req = 1'b1; if_addr = 32'h80; if_req1 = 1'b1;
        step(); check_output("t6_en1", mem_en1, 1); check_output("t6_addr1", mem_addr1, 32'h44);
        step(); check_output("t6_ready1_early", if_ready1, 0);
        step(); check_output("t6_ready1", if_ready1, 1); check_output("t6_rdata1", if_rdata1, 32'h13);
        check_output("t6_ready_early", if_ready, 0);
        if_req1 = 1'b0;
        step(); check_output("t6_ready", if_ready, 1); check_output("t6_rdata", if_rdata, 32'h513);
        if_req = 1'b0;
        check_output("t6_we1", mem_we1, 0); check_output("t6_dm_ready1", dm_ready1, 0);
        check_output("t6_dm_rdata1", dm_rdata1, 0); check_output("t6_wdata1", mem_wdata1, 0);

        step(); dm_read = 1'b1; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            check_output("t5_alternate", mem_addr, (k % 2 == 0) ? 32'h40 : 32'h100);
            repeat (3) step();
            if (k == 3) begin
                dm_read = 1'b0;
                if_req = 1'b0;
            end
            step();
        end

        repeat (3000) begin
            step();
            apply_stimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
